// File: rtl/clk_tick_scheduler.sv
// Clock-enable scheduler: pixel-rate enable plus a game-logic tick with
// selectable rate, pause and single-step, all on the clkin domain.
module clk_tick_scheduler #(
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned TICK_DIV = 833333,
  parameter int unsigned CNT_W    = 21
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        pause,
  input  logic        step,
  input  logic [1:0]  speed,
  output logic        pix_ce,
  output logic        game_tick,
  output logic        paused,
  output logic [15:0] tick_count
);

  localparam int unsigned PIX_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned TCOUNT_W = 16;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] PER_NORM = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] PER_SLOW = CNT_W'(2 * TICK_DIV);
  localparam logic [CNT_W-1:0] PER_FAST = CNT_W'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic                 step_dly_q, step_dly_d;
  logic                 pix_ce_q, pix_ce_d;
  logic                 game_tick_q, game_tick_d;
  logic                 paused_q, paused_d;
  logic [TCOUNT_W-1:0]  tick_count_q, tick_count_d;
  logic                 step_rise;
  logic                 tick_wrap;

  // Speed code to tick period; 11 falls back to normal.
  function automatic logic [CNT_W-1:0] period_sel(input logic [1:0] spd);
    logic [CNT_W-1:0] per;
    case (spd)
      2'b01:   per = PER_SLOW;
      2'b10:   per = PER_FAST;
      default: per = PER_NORM;
    endcase
    return per;
  endfunction

  // Pixel enable divider, free-running regardless of game state.
  always_comb begin
    pix_cnt_d = pix_cnt_q + PIX_W'(1);
    pix_ce_d  = 1'b0;
    if (pix_cnt_q == PIX_LAST) begin
      pix_cnt_d = '0;
      pix_ce_d  = 1'b1;
    end
  end

  assign step_rise  = step & ~step_dly_q;
  assign step_dly_d = step;
  assign tick_wrap  = (tick_cnt_q == period_q - CNT_W'(1));

  // Game FSM: next state, tick counter, period latch and tick pulse.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    period_d    = period_q;
    game_tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tick_wrap) begin
          // A wrap always emits its tick, even if pause arrives on this edge.
          tick_cnt_d  = '0;
          game_tick_d = 1'b1;
          period_d    = period_sel(speed);
          if (pause) begin
            state_d = ST_PAUSED;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_RUN;
        end else if (step_rise) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        tick_cnt_d  = '0;
        game_tick_d = 1'b1;
        period_d    = period_sel(speed);
        state_d     = pause ? ST_PAUSED : ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Status outputs track the post-edge state and tick pulse.
  always_comb begin
    paused_d     = (state_d != ST_RUN);
    tick_count_d = tick_count_q + TCOUNT_W'(game_tick_d);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pix_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      period_q     <= PER_NORM;
      step_dly_q   <= 1'b0;
      pix_ce_q     <= 1'b0;
      game_tick_q  <= 1'b0;
      paused_q     <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      period_q     <= period_d;
      step_dly_q   <= step_dly_d;
      pix_ce_q     <= pix_ce_d;
      game_tick_q  <= game_tick_d;
      paused_q     <= paused_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign pix_ce     = pix_ce_q;
  assign game_tick  = game_tick_q;
  assign paused     = paused_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// Scoreboard bench for clk_tick_scheduler: a countdown reference model queues
// expected per-cycle levels and tick events; a monitor pops and compares them.
module tb_clk_tick_scheduler;

  localparam int unsigned PIX_DIV  = 4;
  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned CNT_W    = 21;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic        pause;
  logic        step;
  logic [1:0]  speed;
  logic        pix_ce;
  logic        game_tick;
  logic        paused;
  logic [15:0] tick_count;

  clk_tick_scheduler #(
    .PIX_DIV (PIX_DIV),
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pause     (pause),
    .step      (step),
    .speed     (speed),
    .pix_ce    (pix_ce),
    .game_tick (game_tick),
    .paused    (paused),
    .tick_count(tick_count)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic        pix;
    logic        pau;
    logic [15:0] cnt;
  } lvl_t;

  typedef struct {
    int unsigned cyc;
    logic [15:0] cnt;
  } tick_t;

  lvl_t  lvl_q[$];
  tick_t tick_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: mode 0 running, 1 paused, 2 single-step pending.
  int unsigned m_edge = 0;
  int unsigned m_since = 0;
  int          m_rem = TICK_DIV;
  int          m_mode = 0;
  bit          m_step_prev = 1'b0;
  logic [15:0] m_count = 16'h0;
  int unsigned mon_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int per_of(input logic [1:0] s);
    case (s)
      2'b01:   return 2 * TICK_DIV;
      2'b10:   return TICK_DIV / 2;
      default: return TICK_DIV;
    endcase
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit    fire;
    lvl_t  l;
    tick_t t;
    m_edge++;
    fire = 1'b0;
    if (!rst_n) begin
      m_since = 0;
      m_mode = 0;
      m_rem = TICK_DIV;
      m_step_prev = 1'b0;
      m_count = 16'h0;
    end else begin
      m_since++;
      case (m_mode)
        0: begin
          if (m_rem == 1) begin
            fire = 1'b1;
            m_rem = per_of(speed);
            if (pause) m_mode = 1;
          end else if (pause) begin
            m_mode = 1;
          end else begin
            m_rem--;
          end
        end
        1: begin
          if (!pause) m_mode = 0;
          else if (step && !m_step_prev) m_mode = 2;
        end
        default: begin
          fire = 1'b1;
          m_rem = per_of(speed);
          m_mode = pause ? 1 : 0;
        end
      endcase
      m_step_prev = step;
    end
    if (fire) begin
      m_count = m_count + 16'h1;
      t.cyc = m_edge;
      t.cnt = m_count;
      tick_q.push_back(t);
    end
    l.pix = rst_n && ((m_since % PIX_DIV) == 0);
    l.pau = (m_mode != 0);
    l.cnt = m_count;
    lvl_q.push_back(l);
  endtask

  task automatic tick_clk();
    model_edge();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic run(input int n);
    repeat (n) tick_clk();
  endtask

  // Monitor: every cycle pops the level record; each game_tick pops a tick event.
  initial begin : monitor
    lvl_t  l;
    tick_t t;
    forever begin
      @(posedge clkin);
      mon_cyc++;
      #1;
      if (lvl_q.size() == 0) begin
        chk("level_underflow", 32'(lvl_q.size()), 32'd1);
      end else begin
        l = lvl_q.pop_front();
        chk("pix_ce", 32'(pix_ce), 32'(l.pix));
        chk("paused", 32'(paused), 32'(l.pau));
        chk("tick_count", 32'(tick_count), 32'(l.cnt));
      end
      if (game_tick !== 1'b0) begin
        if (tick_q.size() == 0) begin
          chk("game_tick_unexpected", 32'(game_tick), 32'd0);
        end else begin
          t = tick_q.pop_front();
          chk("tick_cycle", mon_cyc, t.cyc);
          chk("tick_value", 32'(tick_count), 32'(t.cnt));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit found;
    rst_n = 1'b0;
    pause = 1'b0;
    step  = 1'b0;
    speed = 2'b00;
    run(3);

    // Baseline: normal speed, no pause.
    rst_n = 1'b1;
    run(100);

    // Speed changes mid-period apply from the next wrap.
    rst_n = 1'b0; run(2); rst_n = 1'b1;
    run(14); speed = 2'b01;
    run(40); speed = 2'b10;
    run(46); speed = 2'b00;

    // Pause mid-period, then resume from the held count.
    rst_n = 1'b0; run(2); rst_n = 1'b1;
    run(12); pause = 1'b1;
    run(20); pause = 1'b0;
    run(30);

    // Single steps while paused; held step gives no extra ticks.
    pause = 1'b1; run(5);
    repeat (2) begin
      step = 1'b1; run(3);
      step = 1'b0; run(4);
    end
    // Release pause on the same edge as a step rise: no step tick.
    pause = 1'b0; step = 1'b1; run(1);
    step = 1'b0; run(3);
    // Step toggling while running is ignored.
    repeat (4) begin
      step = 1'b1; run(2);
      step = 1'b0; run(2);
    end

    // Pause arriving exactly on a wrap edge still emits the tick.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_mode == 0 && m_rem == 1) found = 1'b1;
      else tick_clk();
    end
    chk("wrap_wait", 32'(found), 32'd1);
    pause = 1'b1; run(6);
    pause = 1'b0; run(12);

    // Reset mid-period while paused.
    speed = 2'b01; pause = 1'b1; run(7);
    rst_n = 1'b0; run(1);
    rst_n = 1'b1; pause = 1'b0; speed = 2'b00;
    run(25);

    // tick_count wrap: preload near the top, then let three ticks pass.
    force dut.tick_count_q = 16'hFFFE;
    #1;
    release dut.tick_count_q;
    m_count = 16'hFFFE;
    run(35);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15, 0) == 0) pause = ~pause;
      if ($urandom_range(2, 0) == 0) step = ~step;
      if ($urandom_range(39, 0) == 0) speed = 2'($urandom_range(3, 0));
      rst_n = ($urandom_range(599, 0) != 0);
      tick_clk();
    end

    rst_n = 1'b1; pause = 1'b0; step = 1'b0;
    run(5);
    chk("tick_events_left", 32'(tick_q.size()), 32'd0);
    chk("level_records_left", 32'(lvl_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
